dac_serial_multi: RTL and testbench

- Parametrised N-channel serial DAC driver for the ultrasound transmitter DAC front end.
- Loads one parallel word per channel and shifts all enabled channels out simultaneously, MSB first, on per-channel sclk/sync_n/din lines.
- Drives per-channel DAC power-enable pins.
- Generalises the fixed two-path DAC driver: channel count, frame width, bit rate, sync gap, channel masking and a valid/ready load handshake.

---
 rtl/dac_serial_multi_if.sv | 17 +
 rtl/dac_serial_multi.sv | 205 ++++++++++++++++++++
 tb/tb_dac_serial_multi.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_serial_multi_if.sv
// Load handshake between a host and dac_serial_multi: one parallel word per
// channel plus shared control bits, accepted on start && ready.
interface dac_serial_multi_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 16,
    parameter int CTRL_W = 8
);
    logic                           start;
    logic [NUM_CH-1:0][DATA_W-1:0]  ch_data;
    logic [CTRL_W-1:0]              ctrl;
    logic [NUM_CH-1:0]              ch_mask;
    logic                           ready;
    logic                           done;

    modport master (output start, ch_data, ctrl, ch_mask, input ready, done);
    modport slave  (input start, ch_data, ctrl, ch_mask, output ready, done);
endinterface

// File: rtl/dac_serial_multi.sv
// N-channel serial DAC driver: frames {ctrl, ch_data[k]} MSB first on per-channel
// sclk/sync_n/din. Optional macro DAC_AUTO_REPEAT_EN adds auto_en for back-to-back frames.
module dac_lane #(
    parameter int FRAME_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic               shift,
    input  logic               en_in,
    input  logic [FRAME_W-1:0] word_in,
    input  logic               frame_on,
    input  logic               sclk_on,
    output logic               sclk,
    output logic               sync_n,
    output logic               din
);
    logic [FRAME_W-1:0] sh, sh_nxt;
    logic               en, en_nxt;

    always_comb begin
        en_nxt = load ? en_in : en;
        sh_nxt = sh;
        if (load)
            sh_nxt = word_in;
        else if (shift)
            sh_nxt = {sh[FRAME_W-2:0], 1'b0};
    end

    // Pins are registered from the next-cycle view so every lane stays cycle-aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh     <= '0;
            en     <= 1'b0;
            sclk   <= 1'b0;
            sync_n <= 1'b1;
            din    <= 1'b0;
        end else begin
            sh     <= sh_nxt;
            en     <= en_nxt;
            sclk   <= sclk_on & en_nxt;
            sync_n <= ~(frame_on & en_nxt);
            din    <= frame_on & en_nxt & sh_nxt[FRAME_W-1];
        end
    end
endmodule

module dac_serial_multi #(
    parameter int NUM_CH   = 2,
    parameter int DATA_W   = 16,
    parameter int FRAME_W  = 24,
    parameter int CLK_DIV  = 4,
    parameter int SYNC_GAP = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef DAC_AUTO_REPEAT_EN
    input  logic              auto_en,
`endif
    dac_serial_multi_if.slave bus,
    output logic [NUM_CH-1:0] pwr_en,
    output logic [NUM_CH-1:0] sclk,
    output logic [NUM_CH-1:0] sync_n,
    output logic [NUM_CH-1:0] din
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BIT_W = $clog2(FRAME_W);
    localparam int GAP_W = (SYNC_GAP > 1) ? $clog2(SYNC_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(SYNC_GAP - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

    state_t             state, state_nxt;
    logic [DIV_W-1:0]   div_cnt, div_nxt;
    logic [BIT_W-1:0]   bit_cnt, bit_nxt;
    logic [GAP_W-1:0]   gap_cnt, gap_nxt;
    logic               sclk_hi, sclk_nxt;
    logic               ready, ready_nxt;
    logic               done, done_nxt;
    logic               frame_nxt;
    logic               load, shift;
    logic               repeat_req;

`ifdef DAC_AUTO_REPEAT_EN
    assign repeat_req = auto_en;
`else
    assign repeat_req = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sclk_hi <= 1'b0;
            ready   <= 1'b0;
            done    <= 1'b0;
            pwr_en  <= '0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            gap_cnt <= gap_nxt;
            sclk_hi <= sclk_nxt;
            ready   <= ready_nxt;
            done    <= done_nxt;
            pwr_en  <= '1;
        end
    end

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        sclk_nxt  = 1'b0;
        frame_nxt = 1'b0;
        ready_nxt = 1'b0;
        done_nxt  = 1'b0;
        load      = 1'b0;
        shift     = 1'b0;
        case (state)
            IDLE: begin
                ready_nxt = 1'b1;
                if (bus.start && ready) begin
                    load      = 1'b1;
                    state_nxt = SETUP;
                    div_nxt   = DIV_LAST;
                    frame_nxt = 1'b1;
                    ready_nxt = 1'b0;
                end
            end
            SETUP: begin
                frame_nxt = 1'b1;
                if (div_cnt == '0) begin
                    state_nxt = SHIFT;
                    div_nxt   = DIV_LAST;
                    bit_nxt   = BIT_LAST;
                    sclk_nxt  = 1'b1;
                end else begin
                    div_nxt = div_cnt - 1'b1;
                end
            end
            SHIFT: begin
                frame_nxt = 1'b1;
                sclk_nxt  = sclk_hi;
                if (div_cnt != '0) begin
                    div_nxt = div_cnt - 1'b1;
                end else if (sclk_hi) begin
                    sclk_nxt = 1'b0;
                    div_nxt  = DIV_LAST;
                end else if (bit_cnt != '0) begin
                    // Next bit is presented together with the sclk rising edge.
                    sclk_nxt = 1'b1;
                    shift    = 1'b1;
                    bit_nxt  = bit_cnt - 1'b1;
                    div_nxt  = DIV_LAST;
                end else begin
                    frame_nxt = 1'b0;
                    sclk_nxt  = 1'b0;
                    state_nxt = GAP;
                    gap_nxt   = GAP_LAST;
                    done_nxt  = (SYNC_GAP == 1);
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_nxt  = gap_cnt - 1'b1;
                    done_nxt = (gap_cnt == GAP_W'(1));
                end else if (repeat_req) begin
                    load      = 1'b1;
                    state_nxt = SETUP;
                    div_nxt   = DIV_LAST;
                    frame_nxt = 1'b1;
                end else begin
                    state_nxt = IDLE;
                    ready_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.ready = ready;
    assign bus.done  = done;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
        dac_lane #(.FRAME_W(FRAME_W)) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load),
            .shift    (shift),
            .en_in    (bus.ch_mask[k]),
            .word_in  ({bus.ctrl, bus.ch_data[k]}),
            .frame_on (frame_nxt),
            .sclk_on  (sclk_nxt),
            .sclk     (sclk[k]),
            .sync_n   (sync_n[k]),
            .din      (din[k])
        );
    end
endmodule

// File: tb/tb_dac_serial_multi.sv
// Randomized bench for dac_serial_multi: accepted loads feed a scoreboard that a
// pin-level monitor checks at every done pulse (captured words, timing, masking).
module tb_dac_serial_multi;
    localparam int NUM_CH   = 2;
    localparam int DATA_W   = 16;
    localparam int FRAME_W  = 24;
    localparam int CLK_DIV  = 4;
    localparam int SYNC_GAP = 4;
    localparam int CTRL_W   = FRAME_W - DATA_W;
    localparam int LOW_CYC  = CLK_DIV * (1 + 2 * FRAME_W);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef DAC_AUTO_REPEAT_EN
    logic auto_en = 1'b0;
`endif
    logic [NUM_CH-1:0] pwr_en, sclk, sync_n, din;

    dac_serial_multi_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .CTRL_W(CTRL_W)) bus ();

    dac_serial_multi #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .FRAME_W(FRAME_W),
        .CLK_DIV(CLK_DIV), .SYNC_GAP(SYNC_GAP)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
`ifdef DAC_AUTO_REPEAT_EN
        .auto_en(auto_en),
`endif
        .bus    (bus),
        .pwr_en (pwr_en),
        .sclk   (sclk),
        .sync_n (sync_n),
        .din    (din)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [NUM_CH-1:0][FRAME_W-1:0] word;
        logic [NUM_CH-1:0]              mask;
        int                             acc;
    } exp_t;

    exp_t sbq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   last_done = -1000;
    int   last_acc = -1000;
    bit   b2b_chk = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: whatever is on the bus when a load is accepted is what the DAC must see.
    always @(negedge clk) begin
        logic acc, auto_acc;
        exp_t e;
        if (rst_n) begin
            auto_acc = 1'b0;
`ifdef DAC_AUTO_REPEAT_EN
            auto_acc = bus.done && auto_en;
`endif
            acc = (bus.start && bus.ready) || auto_acc;
            if (acc) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    e.mask[k] = bus.ch_mask[k];
                    e.word[k] = bus.ch_mask[k] ? {bus.ctrl, bus.ch_data[k]} : '0;
                end
                e.acc = cyc + 1;
                if (b2b_chk && !auto_acc)
                    check("b2b_spacing", e.acc - last_done, 2);
                if (auto_acc)
                    check("auto_period", e.acc - last_acc, LOW_CYC + SYNC_GAP);
                last_acc = e.acc;
                sbq.push_back(e);
            end
        end
    end

    int                 low_cnt[NUM_CH];
    int                 fall_cnt[NUM_CH];
    int                 stray[NUM_CH];
    logic [FRAME_W-1:0] cap[NUM_CH];
    logic [NUM_CH-1:0]  sclk_prev = '0;
    bit                 rdy_pend = 1'b0;
    bit                 rdy_exp = 1'b1;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                low_cnt[k] = 0; fall_cnt[k] = 0; stray[k] = 0; cap[k] = '0;
            end
            sclk_prev = '0;
            rdy_pend  = 1'b0;
        end else begin
            if (rdy_pend) begin
                check("ready_after_done", bus.ready, rdy_exp);
                rdy_pend = 1'b0;
            end
            for (int k = 0; k < NUM_CH; k++) begin
                if (!sync_n[k]) begin
                    low_cnt[k]++;
                    if (sclk_prev[k] && !sclk[k]) begin
                        fall_cnt[k]++;
                        cap[k] = {cap[k][FRAME_W-2:0], din[k]};
                    end
                end else if (sclk[k] || din[k]) begin
                    stray[k]++;
                end
            end
            sclk_prev = sclk;
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    check("done_without_accept", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    check("done_time", cyc - e.acc, LOW_CYC + SYNC_GAP - 1);
                    for (int k = 0; k < NUM_CH; k++) begin
                        check($sformatf("word_ch%0d", k), cap[k], e.word[k]);
                        check($sformatf("sync_low_ch%0d", k), low_cnt[k], e.mask[k] ? LOW_CYC : 0);
                        check($sformatf("sclk_falls_ch%0d", k), fall_cnt[k], e.mask[k] ? FRAME_W : 0);
                        check($sformatf("idle_pins_ch%0d", k), stray[k], 0);
                    end
                end
                for (int k = 0; k < NUM_CH; k++) begin
                    low_cnt[k] = 0; fall_cnt[k] = 0; stray[k] = 0; cap[k] = '0;
                end
                last_done = cyc;
                rdy_pend  = 1'b1;
                rdy_exp   = 1'b1;
`ifdef DAC_AUTO_REPEAT_EN
                rdy_exp   = !auto_en;
`endif
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!bus.ready && t < 1000) begin tick(); t++; end
        if (t >= 1000) check("ready_timeout", 1, 0);
    endtask

    task automatic wait_done();
        int t = 0;
        while (!bus.done && t < 1000) begin tick(); t++; end
        if (t >= 1000) check("done_timeout", 1, 0);
    endtask

    task automatic send_frame(input logic [NUM_CH-1:0][DATA_W-1:0] d,
                              input logic [CTRL_W-1:0] c,
                              input logic [NUM_CH-1:0] m,
                              input bit noise);
        wait_ready();
        bus.ch_data = d; bus.ctrl = c; bus.ch_mask = m; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        if (noise) begin
            for (int i = 0; i < 150; i++) begin
                bus.start   = 1'($urandom_range(0, 1));
                bus.ch_data = 32'($urandom);
                bus.ctrl    = 8'($urandom);
                bus.ch_mask = 2'($urandom);
                tick();
            end
            bus.start = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0; bus.ch_data = '0; bus.ctrl = '0; bus.ch_mask = '0;
        tick(3);
        check("rst_pwr_en", pwr_en, 2'b00);
        check("rst_ready", bus.ready, 0);
        check("rst_done", bus.done, 0);
        check("rst_sync_n", sync_n, 2'b11);
        check("rst_sclk", sclk, 2'b00);
        check("rst_din", din, 2'b00);
        rst_n = 1'b1;
        tick();
        check("rel_pwr_en", pwr_en, 2'b11);
        check("rel_ready", bus.ready, 1);
        tick(5);
        check("idle_pins", {sync_n, sclk, din}, 6'b110000);

        send_frame({16'hA5C3, 16'h1234}, 8'h00, 2'b11, 1'b0);
        wait_done();
        send_frame({16'hA5C3, 16'h1234}, 8'h00, 2'b01, 1'b0);
        wait_done();
        send_frame(32'($urandom), 8'($urandom), 2'b00, 1'b0);
        wait_done();

        for (int i = 0; i < 6; i++) begin
            send_frame(32'($urandom), 8'($urandom), 2'($urandom), 1'b1);
            wait_done();
        end

        // start held high: frames must run back-to-back
        wait_ready();
        bus.start = 1'b1; bus.ch_mask = 2'b11;
        bus.ch_data = 32'($urandom); bus.ctrl = 8'($urandom);
        tick();
        wait_done();
        b2b_chk = 1'b1;
        for (int f = 0; f < 3; f++) begin
            tick(20);
            bus.ch_data = 32'($urandom); bus.ctrl = 8'($urandom);
            wait_done();
        end
        bus.start = 1'b0;
        b2b_chk = 1'b0;
        tick(2);

        // reset during bit 10 of the shift phase
        send_frame(32'($urandom), 8'($urandom), 2'b11, 1'b0);
        tick(109);
        rst_n = 1'b0;
        sbq.delete();
        #1;
        check("midrst_pwr_en", pwr_en, 2'b00);
        check("midrst_sync_n", sync_n, 2'b11);
        check("midrst_sclk_din", {sclk, din}, 4'b0000);
        check("midrst_ready", bus.ready, 0);
        tick(2);
        rst_n = 1'b1;
        tick();
        check("midrst_rel_pwr_en", pwr_en, 2'b11);
        send_frame(32'($urandom), 8'($urandom), 2'b11, 1'b0);
        wait_done();

`ifdef DAC_AUTO_REPEAT_EN
        tick(2);
        auto_en = 1'b1;
        send_frame(32'($urandom), 8'($urandom), 2'b11, 1'b0);
        tick(40);
        bus.ch_data = 32'($urandom); bus.ctrl = 8'($urandom);
        wait_done();
        tick(40);
        bus.ch_data = 32'($urandom); bus.ch_mask = 2'($urandom);
        wait_done();
        tick(50);
        auto_en = 1'b0;
        wait_done();
`endif

        tick(5);
        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
